// File: rtl/seq_penc_pkg.sv
// Shared definitions for the sequential priority encoder: FSM state codes and
// width derivation helpers.
package seq_penc_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    // Index width; a 1-bit index is kept even for degenerate widths.
    function automatic int unsigned idx_w_f(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // Popcount width, sized so an all-ones vector's count fits.
    function automatic int unsigned cnt_w_f(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_priority_encoder_prio_enc_comb.sv
// Combinational priority encoder returning the winning index, an any-set flag
// and a one-hot mask of the selected bit.
module prio_enc_comb
    import seq_penc_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned IDX_W    = idx_w_f(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any,
    output logic [WIDTH-1:0] o_onehot
);

    // Later loop iterations override earlier ones, so scan toward the winner.
    always_comb begin
        o_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (i_vec[i]) o_idx = IDX_W'(i);
            end else begin
                if (i_vec[WIDTH-1-i]) o_idx = IDX_W'(WIDTH - 1 - i);
            end
        end
    end

    assign o_any    = |i_vec;
    assign o_onehot = o_any ? (WIDTH'(1) << o_idx) : '0;

endmodule

// File: rtl/seq_priority_encoder.sv
// Accepts a request vector and emits the index of each set bit, one per
// handshaked output beat, in priority order.
module seq_priority_encoder
    import seq_penc_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned IDX_W    = idx_w_f(WIDTH),
    localparam int unsigned CNT_W    = cnt_w_f(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [CNT_W-1:0] out_cnt
);

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_residual;
    logic [CNT_W-1:0] r_cnt;
    logic             r_none;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_residual_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_none_nxt;

    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    logic [WIDTH-1:0] w_onehot;
    logic             w_single;
    logic             w_last;

    prio_enc_comb #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio_enc (
        .i_vec    (r_residual),
        .o_idx    (w_idx),
        .o_any    (w_any),
        .o_onehot (w_onehot)
    );

    // Exactly one bit left means the current beat is the vector's last.
    assign w_single = w_any && ((r_residual & (r_residual - WIDTH'(1))) == '0);
    assign w_last   = w_single || r_none;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_residual <= '0;
            r_cnt      <= '0;
            r_none     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_residual <= w_residual_nxt;
            r_cnt      <= w_cnt_nxt;
            r_none     <= w_none_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_residual_nxt = r_residual;
        w_cnt_nxt      = r_cnt;
        w_none_nxt     = r_none;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_residual_nxt = in_vec;
                    w_cnt_nxt      = popcount(in_vec);
                    w_none_nxt     = (in_vec == '0);
                    w_state_nxt    = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (w_last) begin
                        w_residual_nxt = '0;
                        w_none_nxt     = 1'b0;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_residual_nxt = r_residual & ~w_onehot;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == EMIT);
    assign out_idx   = w_idx;
    assign out_last  = w_last;
    assign out_none  = r_none;
    assign out_cnt   = r_cnt;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Scoreboard bench: directed vectors push hand-computed beats; per-DUT monitors
// compare every presented beat (stalled beats are checked without popping).
module tb_seq_priority_encoder;

    typedef struct {
        int idx;
        int last;
        int none;
        int cnt;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, out_last4, out_none4;
    logic [3:0] in_vec4;
    logic [1:0] out_idx4;
    logic [2:0] out_cnt4;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, out_last8, out_none8;
    logic [7:0] in_vec8;
    logic [2:0] out_idx8;
    logic [3:0] out_cnt8;

    int n_total = 0;
    int n_pass  = 0;
    beat_t q4[$];
    beat_t q8[$];

    seq_priority_encoder #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_vec(in_vec4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_idx(out_idx4),
        .out_last(out_last4), .out_none(out_none4), .out_cnt(out_cnt4)
    );

    seq_priority_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_vec(in_vec8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_idx(out_idx8),
        .out_last(out_last8), .out_none(out_none8), .out_cnt(out_cnt8)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void exp4(input int idx, input int last, input int none, input int cnt);
        beat_t b;
        b.idx = idx; b.last = last; b.none = none; b.cnt = cnt;
        q4.push_back(b);
    endfunction

    function automatic void exp8(input int idx, input int last, input int none, input int cnt);
        beat_t b;
        b.idx = idx; b.last = last; b.none = none; b.cnt = cnt;
        q8.push_back(b);
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid4) begin
            if (q4.size() == 0) begin
                check("beat4_unexpected", 1, 0);
            end else begin
                check("beat4_idx",  int'(out_idx4),  q4[0].idx);
                check("beat4_last", int'(out_last4), q4[0].last);
                check("beat4_none", int'(out_none4), q4[0].none);
                check("beat4_cnt",  int'(out_cnt4),  q4[0].cnt);
                if (out_ready4) void'(q4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid8) begin
            if (q8.size() == 0) begin
                check("beat8_unexpected", 1, 0);
            end else begin
                check("beat8_idx",  int'(out_idx8),  q8[0].idx);
                check("beat8_last", int'(out_last8), q8[0].last);
                check("beat8_none", int'(out_none8), q8[0].none);
                check("beat8_cnt",  int'(out_cnt8),  q8[0].cnt);
                if (out_ready8) void'(q8.pop_front());
            end
        end
    end

    task automatic send4(input logic [3:0] v);
        int n = 0;
        @(negedge clk);
        while (!in_ready4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send4_ready", int'(in_ready4), 1);
        in_valid4 = 1'b1;
        in_vec4   = v;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        in_vec4   = 4'($urandom);
    endtask

    task automatic send8(input logic [7:0] v);
        int n = 0;
        @(negedge clk);
        while (!in_ready8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send8_ready", int'(in_ready8), 1);
        in_valid8 = 1'b1;
        in_vec8   = v;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_vec8   = 8'($urandom);
    endtask

    task automatic drain4(input string name);
        int n = 0;
        while ((q4.size() != 0 || !in_ready4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(n < 50), 1);
    endtask

    task automatic drain8(input string name);
        int n = 0;
        while ((q8.size() != 0 || !in_ready8) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(n < 50), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid4 = 1'b0; in_vec4 = 4'hx; out_ready4 = 1'b1;
        in_valid8 = 1'b0; in_vec8 = 8'hx; out_ready8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  int'(in_ready4),  1);
        check("rst_out_valid", int'(out_valid4), 0);
        check("rst_out_idx",   int'(out_idx4),   0);
        check("rst_out_last",  int'(out_last4),  0);
        check("rst_out_none",  int'(out_none4),  0);
        check("rst_out_cnt",   int'(out_cnt4),   0);
        check("rst8_out_valid", int'(out_valid8), 0);
        rst_n = 1'b1;

        // Single bit: one beat, in_ready returns after the beat handshake.
        exp4(0, 1, 0, 1);
        send4(4'b0001);
        check("one_busy", int'(in_ready4), 0);
        @(posedge clk);
        #1;
        check("one_ready_back", int'(in_ready4), 1);
        drain4("one_drain");

        // Two bits, with garbage presented on the input while emitting.
        exp4(2, 0, 0, 2);
        exp4(1, 1, 0, 2);
        send4(4'b0110);
        in_valid4 = 1'b1;
        in_vec4   = 4'b1001;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        drain4("two_drain");

        // All-zero vector: single none beat.
        exp4(0, 1, 1, 0);
        send4(4'b0000);
        drain4("zero_drain");
        check("zero_none_cleared", int'(out_none4), 0);

        // All ones with a 3-cycle stall on beat 2.
        exp4(3, 0, 0, 4);
        exp4(2, 0, 0, 4);
        exp4(1, 0, 0, 4);
        exp4(0, 1, 0, 4);
        send4(4'b1111);
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready4 = 1'b1;
        drain4("ones_drain");

        // Asynchronous reset after the first beat of 4'b1010.
        exp4(3, 0, 0, 2);
        send4(4'b1010);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid4), 0);
        check("arst_in_ready",  int'(in_ready4),  1);
        check("arst_out_idx",   int'(out_idx4),   0);
        check("arst_out_cnt",   int'(out_cnt4),   0);
        check("arst_out_last",  int'(out_last4),  0);
        check("arst_q_empty",   q4.size(),        0);
        #1;
        rst_n = 1'b1;
        exp4(2, 1, 0, 1);
        send4(4'b0100);
        drain4("post_rst_drain");

        // WIDTH=8, LSB first.
        exp8(0, 0, 0, 2);
        exp8(7, 1, 0, 2);
        send8(8'h81);
        drain8("w8_81_drain");

        for (int i = 0; i < 8; i++) exp8(i, int'(i == 7), 0, 8);
        send8(8'hFF);
        drain8("w8_ff_drain");

        check("end_q4_empty", q4.size(), 0);
        check("end_q8_empty", q8.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
